// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel neighbourhood fetch controller:
// frame size defaults, FSM encoding, neighbour offset table and slot mapping.
package sobel_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int NBR_N     = 8;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLASSIFY = 3'd1;
  localparam logic [2:0] S_BORDER   = 3'd2;
  localparam logic [2:0] S_ISSUE    = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_PRESENT  = 3'd5;
  localparam logic [2:0] S_ADVANCE  = 3'd6;

  // Row delta of neighbour slot k (slots are the 3x3 window in raster order, centre skipped).
  function automatic int nbr_dr(input logic [2:0] k);
    case (k)
      3'd0, 3'd1, 3'd2: return -1;
      3'd3, 3'd4:       return 0;
      default:          return 1;
    endcase
  endfunction

  // Column delta of neighbour slot k.
  function automatic int nbr_dc(input logic [2:0] k);
    case (k)
      3'd0, 3'd3, 3'd5: return -1;
      3'd1, 3'd6:       return 0;
      default:          return 1;
    endcase
  endfunction

  // Window position p (0..8, p != 4) to the slot that holds it.
  function automatic logic [2:0] slot_of_pix(input int p);
    return (p < 4) ? 3'(p) : 3'(p - 1);
  endfunction

endpackage

// File: rtl/sobel_pos_cnt.sv
// Raster position tracker: x/y counters plus a running centre address,
// with border and last-pixel flags derived from them.
module sobel_pos_cnt
  import sobel_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 19
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              adv_i,
  output logic [9:0]        x_o,
  output logic [9:0]        y_o,
  output logic [ADDR_W-1:0] c_o,
  output logic              border_o,
  output logic              last_o
);

  logic [9:0]        x_q, y_q;
  logic [ADDR_W-1:0] c_q;
  logic              x_end;

  assign x_end = (x_q == 10'(IMG_W - 1));

  // Advance one pixel in raster order; the address walks along without a multiplier.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
      c_q <= '0;
    end else if (clear_i) begin
      x_q <= '0;
      y_q <= '0;
      c_q <= '0;
    end else if (adv_i) begin
      c_q <= c_q + 1'b1;
      if (x_end) begin
        x_q <= '0;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign c_o      = c_q;
  assign border_o = (x_q == '0) || x_end || (y_q == '0) || (y_q == 10'(IMG_H - 1));
  assign last_o   = (c_q == ADDR_W'(IMG_W * IMG_H - 1));

endmodule

// File: rtl/sobel_win_fetch_ctrl.sv
// Fetches the 3x3 neighbourhood of every pixel from a single-port BRAM
// and hands each window (centre omitted) to the Sobel core.
//
// state    | meaning
// IDLE     | waiting for start
// CLASSIFY | decide border vs interior for current pixel
// BORDER   | present zeroed window, wait for ready
// ISSUE    | eight neighbour reads, one per cycle
// DRAIN    | wait RD_LAT cycles for the last read data
// PRESENT  | present fetched window, wait for ready
// ADVANCE  | step position or finish the frame
module sobel_win_fetch_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [PIX_W-1:0]  mem_rd_data_i,
  output logic              win_valid_o,
  input  logic              win_ready_i,
  output logic [PIX_W-1:0]  pix_0_o,
  output logic [PIX_W-1:0]  pix_1_o,
  output logic [PIX_W-1:0]  pix_2_o,
  output logic [PIX_W-1:0]  pix_3_o,
  output logic [PIX_W-1:0]  pix_5_o,
  output logic [PIX_W-1:0]  pix_6_o,
  output logic [PIX_W-1:0]  pix_7_o,
  output logic [PIX_W-1:0]  pix_8_o,
  output logic              border_o,
  output logic [9:0]        x_pos_o,
  output logic [9:0]        y_pos_o
);

  logic [2:0]              state_q, state_d;
  logic [2:0]              k_q;
  logic [1:0]              dcnt_q;
  logic [ADDR_W-1:0]       addr_q, addr_nxt;
  logic [RD_LAT-1:0]       tv_q;
  logic [RD_LAT-1:0][2:0]  tk_q;
  logic [PIX_W-1:0]        win_q [NBR_N];
  logic                    pos_clear, pos_adv;
  logic [ADDR_W-1:0]       c_pos;
  logic                    pos_border, pos_last;
  logic                    rd_en, in_border;

  sobel_pos_cnt #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_pos (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (pos_clear),
    .adv_i    (pos_adv),
    .x_o      (x_pos_o),
    .y_o      (y_pos_o),
    .c_o      (c_pos),
    .border_o (pos_border),
    .last_o   (pos_last)
  );

  // Next-state logic and position-counter control.
  always_comb begin
    state_d   = state_q;
    pos_clear = 1'b0;
    pos_adv   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pos_clear = 1'b1;
          state_d   = S_CLASSIFY;
        end
      end
      S_CLASSIFY: state_d = pos_border ? S_BORDER : S_ISSUE;
      S_BORDER:   if (win_ready_i) state_d = S_ADVANCE;
      S_ISSUE:    if (k_q == 3'd7) state_d = S_DRAIN;
      S_DRAIN:    if (dcnt_q == 2'(RD_LAT - 1)) state_d = S_PRESENT;
      S_PRESENT:  if (win_ready_i) state_d = S_ADVANCE;
      S_ADVANCE: begin
        if (pos_last) begin
          state_d = S_IDLE;
        end else begin
          pos_adv = 1'b1;
          state_d = S_CLASSIFY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus read-slot and drain counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= (state_q == S_ISSUE) ? k_q + 1'b1 : 3'd0;
      dcnt_q  <= (state_q == S_DRAIN) ? dcnt_q + 1'b1 : 2'd0;
    end
  end

  // Neighbour address: centre plus row/column offset, wrapping modulo 2^ADDR_W.
  always_comb begin
    int off;
    off      = nbr_dr(k_q) * IMG_W + nbr_dc(k_q);
    addr_nxt = c_pos + ADDR_W'(off);
  end

  assign rd_en       = (state_q == S_ISSUE);
  assign mem_rd_en_o = rd_en;
  assign mem_addr_o  = rd_en ? addr_nxt : addr_q;

  // Remember the last issued address so the bus stays quiet between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    addr_q <= '0;
    else if (rd_en) addr_q <= addr_nxt;
  end

  // Tag pipe matching the BRAM latency; the emerging tag names the slot to fill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tv_q <= '0;
      tk_q <= '0;
    end else begin
      tv_q[0] <= rd_en;
      tk_q[0] <= k_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tv_q[i] <= tv_q[i-1];
        tk_q[i] <= tk_q[i-1];
      end
    end
  end

  // Capture returning read data into its window slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NBR_N; i++) win_q[i] <= '0;
    end else if (tv_q[RD_LAT-1]) begin
      win_q[tk_q[RD_LAT-1]] <= mem_rd_data_i;
    end
  end

  assign in_border   = (state_q == S_BORDER);
  assign win_valid_o = in_border || (state_q == S_PRESENT);
  assign border_o    = in_border;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_ADVANCE) && pos_last;

  assign pix_0_o = in_border ? '0 : win_q[slot_of_pix(0)];
  assign pix_1_o = in_border ? '0 : win_q[slot_of_pix(1)];
  assign pix_2_o = in_border ? '0 : win_q[slot_of_pix(2)];
  assign pix_3_o = in_border ? '0 : win_q[slot_of_pix(3)];
  assign pix_5_o = in_border ? '0 : win_q[slot_of_pix(5)];
  assign pix_6_o = in_border ? '0 : win_q[slot_of_pix(6)];
  assign pix_7_o = in_border ? '0 : win_q[slot_of_pix(7)];
  assign pix_8_o = in_border ? '0 : win_q[slot_of_pix(8)];

endmodule

// File: tb/tb_sobel_win_fetch_ctrl.sv
// Bench for sobel_win_fetch_ctrl on a 4x3 image with mem[a]=a, run side by
// side at RD_LAT=1 (index 0) and RD_LAT=3 (index 1).
module tb_sobel_win_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start;
  logic       busy [2], done [2], rd_en [2], wv [2], wr [2], bd [2];
  logic [18:0] addr [2];
  logic [7:0]  rdata [2];
  logic [9:0]  xp [2], yp [2];
  logic [7:0]  pix [2][8];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt [2];
  bit fdone [2];
  bit skip_gap [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Neighbour value for output position j (pix_0,1,2,3,5,6,7,8) of pixel (x,y).
  function automatic int exp_pix(input int x, input int y, input int j);
    int p;
    p = (j < 4) ? j : j + 1;
    return (y + p / 3 - 1) * 4 + (x + p % 3 - 1);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [7:0] p1, p2, p3;
    int n = 0, win_cnt = 0, rd_cnt = 0, last_hs = 0;

    sobel_win_fetch_ctrl #(
      .IMG_W (4), .IMG_H (3), .ADDR_W (19), .PIX_W (8), .RD_LAT (LAT)
    ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .busy_o        (busy[gi]),
      .done_o        (done[gi]),
      .mem_rd_en_o   (rd_en[gi]),
      .mem_addr_o    (addr[gi]),
      .mem_rd_data_i (rdata[gi]),
      .win_valid_o   (wv[gi]),
      .win_ready_i   (wr[gi]),
      .pix_0_o       (pix[gi][0]),
      .pix_1_o       (pix[gi][1]),
      .pix_2_o       (pix[gi][2]),
      .pix_3_o       (pix[gi][3]),
      .pix_5_o       (pix[gi][4]),
      .pix_6_o       (pix[gi][5]),
      .pix_7_o       (pix[gi][6]),
      .pix_8_o       (pix[gi][7]),
      .border_o      (bd[gi]),
      .x_pos_o       (xp[gi]),
      .y_pos_o       (yp[gi])
    );

    // BRAM model, mem[a] = a, with LAT cycles of read latency.
    always @(posedge clk) begin
      p1 <= addr[gi][7:0];
      p2 <= p1;
      p3 <= p2;
    end
    assign rdata[gi] = (LAT == 1) ? p1 : p3;

    // Scoreboard: every handshake against the raster model, frame totals on done.
    always @(negedge clk) begin
      if (!rst_n) begin
        n = 0; win_cnt = 0; rd_cnt = 0;
      end else begin
        if (rd_en[gi]) rd_cnt++;
        if (wv[gi] && wr[gi]) begin
          int ex, ey;
          bit eb;
          ex = n % 4;
          ey = n / 4;
          eb = (ex == 0) || (ex == 3) || (ey == 0) || (ey == 2);
          check($sformatf("L%0d x_pos win%0d", LAT, n), xp[gi], ex);
          check($sformatf("L%0d y_pos win%0d", LAT, n), yp[gi], ey);
          check($sformatf("L%0d border win%0d", LAT, n), bd[gi], eb);
          for (int j = 0; j < 8; j++)
            check($sformatf("L%0d pix%0d win%0d", LAT, j, n), pix[gi][j],
                  eb ? 0 : exp_pix(ex, ey, j));
          if (n != 0 && !skip_gap[gi])
            check($sformatf("L%0d gap win%0d", LAT, n), cyc - last_hs, eb ? 3 : 11 + LAT);
          skip_gap[gi] = 1'b0;
          last_hs = cyc;
          n++;
          win_cnt++;
        end
        if (done[gi]) begin
          done_cnt[gi]++;
          check($sformatf("L%0d windows per frame", LAT), win_cnt, 12);
          check($sformatf("L%0d reads per frame", LAT), rd_cnt, 16);
          n = 0; win_cnt = 0; rd_cnt = 0;
          fdone[gi] = 1'b1;
        end
      end
    end
  end

  task automatic check_zero(input int g, input string tag);
    check({tag, " busy"}, busy[g], 0);
    check({tag, " done"}, done[g], 0);
    check({tag, " win_valid"}, wv[g], 0);
    check({tag, " mem_rd_en"}, rd_en[g], 0);
    check({tag, " mem_addr"}, addr[g], 0);
    check({tag, " x_pos"}, xp[g], 0);
    check({tag, " y_pos"}, yp[g], 0);
    check({tag, " border"}, bd[g], 0);
    for (int j = 0; j < 8; j++) check($sformatf("%s pix%0d", tag, j), pix[g][j], 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_both(input string tag);
    int t;
    t = 0;
    while (!(fdone[0] && fdone[1]) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({tag, " frame end A"}, fdone[0], 1);
    check({tag, " frame end B"}, fdone[1], 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [7:0] win11 [8];
    win11[0] = 8'd0; win11[1] = 8'd1; win11[2] = 8'd2;  win11[3] = 8'd4;
    win11[4] = 8'd6; win11[5] = 8'd8; win11[6] = 8'd9;  win11[7] = 8'd10;
    done_cnt[0] = 0; done_cnt[1] = 0;
    fdone[0] = 0; fdone[1] = 0;
    skip_gap[0] = 0; skip_gap[1] = 0;
    wr[0] = 1'b1; wr[1] = 1'b1;
    start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero(0, "reset A");
    check_zero(1, "reset B");
    rst_n = 1'b1;
    @(negedge clk);

    // Frame 1: full frame, then a start landing on A's done cycle.
    pulse_start();
    t = 0;
    while (!done[0] && t < 3000) begin @(negedge clk); t++; end
    check("frame1 done A seen", done[0], 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start on done busy A", busy[0], 0);
    check("start on done busy B", busy[1], 1);
    wait_both("frame1");
    repeat (3) @(negedge clk);
    check("after frame1 busy A", busy[0], 0);
    check("after frame1 busy B", busy[1], 0);
    check("frame1 done count A", done_cnt[0], 1);
    check("frame1 done count B", done_cnt[1], 1);

    // Frame 2: start while busy, and stall on A's (1,1) window.
    fdone[0] = 0; fdone[1] = 0;
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    check("start while busy A", busy[0], 1);
    check("start while busy B", busy[1], 1);
    t = 0;
    while (!(rd_en[0] && xp[0] == 10'd1 && yp[0] == 10'd1) && t < 3000) begin
      @(negedge clk); t++;
    end
    check("reached ISSUE(1,1)", rd_en[0], 1);
    wr[0] = 1'b0;
    skip_gap[0] = 1'b1;
    t = 0;
    while (!wv[0] && t < 50) begin @(negedge clk); t++; end
    for (int s = 0; s < 5; s++) begin
      check($sformatf("stall%0d valid", s), wv[0], 1);
      check($sformatf("stall%0d x_pos", s), xp[0], 1);
      check($sformatf("stall%0d y_pos", s), yp[0], 1);
      check($sformatf("stall%0d border", s), bd[0], 0);
      for (int j = 0; j < 8; j++) check($sformatf("stall%0d pix%0d", s, j), pix[0][j], win11[j]);
      @(negedge clk);
    end
    wr[0] = 1'b1;
    wait_both("frame2");
    check("frame2 done count A", done_cnt[0], 2);
    check("frame2 done count B", done_cnt[1], 2);

    // Frame 3: asynchronous reset during the reads of (2,1).
    fdone[0] = 0; fdone[1] = 0;
    @(negedge clk);
    pulse_start();
    t = 0;
    while (!(rd_en[0] && xp[0] == 10'd2 && yp[0] == 10'd1) && t < 3000) begin
      @(negedge clk); t++;
    end
    check("reached ISSUE(2,1)", rd_en[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero(0, "midframe reset A");
    check_zero(1, "midframe reset B");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("no done on abort A", done_cnt[0], 2);
    check("no done on abort B", done_cnt[1], 2);
    check("idle after abort A", busy[0], 0);

    // Frame 4: clean frame from (0,0) after the abort.
    fdone[0] = 0; fdone[1] = 0;
    pulse_start();
    wait_both("frame4");
    check("final done count A", done_cnt[0], 3);
    check("final done count B", done_cnt[1], 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
